// File: rtl/mem_write_checker.sv
// mem_write_checker
// Scoreboard for a processor's memory stores. Expected stores are loaded into a
// FIFO, then compared in order against the live store stream. The block ends in
// PASS when every loaded entry has matched, or in FAIL on a mismatch or timeout.
//
// Ports
//   clk, reset           single clock, synchronous active-high reset
//   exp_valid/exp_ready  expectation load handshake (exp_ready is combinational)
//   exp_addr/data/mask   expected store address, data and byte-lane mask
//   start                leaves LOAD and begins checking
//   MemWrite, MemWriteSelect, DataAdr, WriteData   observed store stream
//   done/pass/fail       registered terminal status
//   fail_code            0 none, 1 mismatch, 2 timeout
//   fail_addr/fail_data  offending store on a mismatch, else 0
//   match_count          number of matched stores
module mem_write_checker #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT     = 20,
    parameter int unsigned IGNORE_EN   = 1,
    parameter int unsigned IGNORE_ADDR = 96
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         exp_valid,
    output logic                         exp_ready,
    input  logic [ADDR_W-1:0]            exp_addr,
    input  logic [DATA_W-1:0]            exp_data,
    input  logic [DATA_W/8-1:0]          exp_mask,
    input  logic                         start,
    input  logic                         MemWrite,
    input  logic [DATA_W/8-1:0]          MemWriteSelect,
    input  logic [ADDR_W-1:0]            DataAdr,
    input  logic [DATA_W-1:0]            WriteData,
    output logic                         done,
    output logic                         pass,
    output logic                         fail,
    output logic [1:0]                   fail_code,
    output logic [ADDR_W-1:0]            fail_addr,
    output logic [DATA_W-1:0]            fail_data,
    output logic [$clog2(DEPTH+1)-1:0]   match_count
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned CYC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PASS = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_MISMATCH = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd2;

    // Expectation FIFO storage
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [NB-1:0]     fifo_mask [DEPTH];

    logic [1:0]        state, state_n;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_n;
    logic [CYC_W-1:0]  cyc, cyc_n;
    logic [CNT_W-1:0]  match_n;
    logic              done_n, pass_n, fail_n;
    logic [1:0]        code_n;
    logic [ADDR_W-1:0] faddr_n;
    logic [DATA_W-1:0] fdata_n;

    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [NB-1:0]     head_mask;
    logic [DATA_W-1:0] lane_en;
    logic              push, pop, ignored, checked, hit;

    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];
    assign head_mask = fifo_mask[rd_ptr];

    assign exp_ready = (state == ST_LOAD) && (count < CNT_W'(DEPTH));
    assign push      = exp_valid && exp_ready;

    // Stores to the ignore address never touch the FIFO or counters
    assign ignored = (IGNORE_EN != 0) && (DataAdr == ADDR_W'(IGNORE_ADDR));
    assign checked = (state == ST_RUN) && MemWrite && !ignored;

    // Expand the byte mask so unmasked lanes drop out of the data compare
    always_comb begin
        lane_en = '0;
        for (int i = 0; i < NB; i++) begin
            lane_en[i*8 +: 8] = {8{head_mask[i]}};
        end
    end

    assign hit = (DataAdr == head_addr)
              && (MemWriteSelect == head_mask)
              && (((WriteData ^ head_data) & lane_en) == '0);
    assign pop = checked && hit;

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        count_n = count;
        cyc_n   = cyc;
        match_n = match_count;
        done_n  = done;
        pass_n  = pass;
        fail_n  = fail;
        code_n  = fail_code;
        faddr_n = fail_addr;
        fdata_n = fail_data;

        // A handshake on the start cycle still lands before the transition
        if (push) begin
            count_n = count + CNT_W'(1);
        end

        case (state)
            ST_LOAD: begin
                if (start) begin
                    cyc_n = '0;
                    if (count_n != '0) begin
                        state_n = ST_RUN;
                    end else begin
                        state_n = ST_PASS;
                        done_n  = 1'b1;
                        pass_n  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cyc_n = cyc + CYC_W'(1);
                if (checked) begin
                    if (hit) begin
                        count_n = count - CNT_W'(1);
                        match_n = match_count + CNT_W'(1);
                        if (count == CNT_W'(1)) begin
                            state_n = ST_PASS;
                            done_n  = 1'b1;
                            pass_n  = 1'b1;
                        end
                    end else begin
                        state_n = ST_FAIL;
                        done_n  = 1'b1;
                        fail_n  = 1'b1;
                        code_n  = CODE_MISMATCH;
                        faddr_n = DataAdr;
                        fdata_n = WriteData;
                    end
                end
                // Timeout only applies when the store decision left us in RUN
                if ((state_n == ST_RUN) && (cyc == CYC_W'(TIMEOUT - 1))) begin
                    state_n = ST_FAIL;
                    done_n  = 1'b1;
                    fail_n  = 1'b1;
                    code_n  = CODE_TIMEOUT;
                end
            end
            default: begin
                // PASS and FAIL hold until reset
            end
        endcase
    end

    // State, control and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_LOAD;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cyc         <= '0;
            match_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= CODE_NONE;
            fail_addr   <= '0;
            fail_data   <= '0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            cyc         <= cyc_n;
            match_count <= match_n;
            done        <= done_n;
            pass        <= pass_n;
            fail        <= fail_n;
            fail_code   <= code_n;
            fail_addr   <= faddr_n;
            fail_data   <= fdata_n;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO payload write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= exp_addr;
            fifo_data[wr_ptr] <= exp_data;
            fifo_mask[wr_ptr] <= exp_mask;
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker
// Self-checking bench for mem_write_checker (DEPTH=4, TIMEOUT=20). Expected
// terminal results are queued when a scenario is driven and compared when the
// checker raises done.
module tb_mem_write_checker;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned NB      = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned MCW     = 3;

    typedef struct packed {
        logic          pass;
        logic          fail;
        logic [1:0]    code;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MCW-1:0] mc;
    } res_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           exp_valid;
    logic           exp_ready;
    logic [AW-1:0]  exp_addr;
    logic [DW-1:0]  exp_data;
    logic [NB-1:0]  exp_mask;
    logic           start;
    logic           MemWrite;
    logic [NB-1:0]  MemWriteSelect;
    logic [AW-1:0]  DataAdr;
    logic [DW-1:0]  WriteData;
    logic           done, pass, fail;
    logic [1:0]     fail_code;
    logic [AW-1:0]  fail_addr;
    logic [DW-1:0]  fail_data;
    logic [MCW-1:0] match_count;

    res_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_write_checker #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT),
        .IGNORE_EN(1), .IGNORE_ADDR(96)
    ) dut (
        .clk(clk), .reset(reset),
        .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_mask(exp_mask),
        .start(start),
        .MemWrite(MemWrite), .MemWriteSelect(MemWriteSelect),
        .DataAdr(DataAdr), .WriteData(WriteData),
        .done(done), .pass(pass), .fail(fail), .fail_code(fail_code),
        .fail_addr(fail_addr), .fail_data(fail_data), .match_count(match_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] m);
        exp_valid = 1'b1;
        exp_addr  = a;
        exp_data  = d;
        exp_mask  = m;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] m);
        MemWrite       = 1'b1;
        DataAdr        = a;
        WriteData      = d;
        MemWriteSelect = m;
        tick();
        MemWrite       = 1'b0;
    endtask

    task automatic expect_result(input logic p, input logic f, input logic [1:0] c,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [MCW-1:0] mc);
        res_t r;
        r.pass = p; r.fail = f; r.code = c; r.addr = a; r.data = d; r.mc = mc;
        sb.push_back(r);
    endtask

    // Wait (bounded) for done, then compare status against the queued result
    task automatic wait_done(input string tag, input int budget, output int cycles);
        res_t r;
        cycles = 0;
        while (!done && cycles < budget) begin
            tick();
            cycles++;
        end
        check({tag, "_done"}, 64'(done), 64'(1));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(0), 64'(1));
        end else begin
            r = sb.pop_front();
            check({tag, "_pass"},  64'(pass),        64'(r.pass));
            check({tag, "_fail"},  64'(fail),        64'(r.fail));
            check({tag, "_code"},  64'(fail_code),   64'(r.code));
            check({tag, "_faddr"}, 64'(fail_addr),   64'(r.addr));
            check({tag, "_fdata"}, 64'(fail_data),   64'(r.data));
            check({tag, "_mcount"},64'(match_count), 64'(r.mc));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_done"},  64'(done),        64'(0));
        check({tag, "_pass"},  64'(pass),        64'(0));
        check({tag, "_fail"},  64'(fail),        64'(0));
        check({tag, "_code"},  64'(fail_code),   64'(0));
        check({tag, "_faddr"}, 64'(fail_addr),   64'(0));
        check({tag, "_fdata"}, 64'(fail_data),   64'(0));
        check({tag, "_mcount"},64'(match_count), 64'(0));
        check({tag, "_ready"}, 64'(exp_ready),   64'(1));
    endtask

    initial begin
        int cyc;
        int hs;
        reset = 1'b0; exp_valid = 1'b0; exp_addr = '0; exp_data = '0; exp_mask = '0;
        start = 1'b0; MemWrite = 1'b0; MemWriteSelect = '0; DataAdr = '0; WriteData = '0;

        // Reset state
        do_reset();
        check_idle("rst");

        // Basic pass with an ignored store first
        load(32'd100, 32'd25, 4'hF);
        pulse_start();
        store(32'd96, 32'd7, 4'hF);
        check("ign_done", 64'(done), 64'(0));
        check("ign_mcount", 64'(match_count), 64'(0));
        expect_result(1'b1, 1'b0, 2'd0, '0, '0, 3'd1);
        store(32'd100, 32'd25, 4'hF);
        wait_done("basic", 5, cyc);
        check("basic_latency", 64'(cyc), 64'(0));
        // Terminal state is absorbing
        store(32'd100, 32'd99, 4'hF);
        pulse_start();
        check("absorb_pass", 64'(pass), 64'(1));
        check("absorb_fail", 64'(fail), 64'(0));
        check("absorb_mcount", 64'(match_count), 64'(1));

        // Data mismatch; a store during LOAD is ignored
        do_reset();
        load(32'd100, 32'd25, 4'hF);
        store(32'd5, 32'd5, 4'hF);
        pulse_start();
        expect_result(1'b0, 1'b1, 2'd1, 32'd100, 32'd26, 3'd0);
        store(32'd100, 32'd26, 4'hF);
        wait_done("mism", 5, cyc);
        check("mism_latency", 64'(cyc), 64'(0));

        // Timeout exactly TIMEOUT cycles after RUN entry
        do_reset();
        load(32'd100, 32'd25, 4'hF);
        pulse_start();
        expect_result(1'b0, 1'b1, 2'd2, '0, '0, 3'd0);
        wait_done("tmo", 40, cyc);
        check("tmo_latency", 64'(cyc), 64'(TIMEOUT));

        // FIFO full after DEPTH handshakes
        do_reset();
        hs = 0;
        exp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_addr = 32'h200 + 32'(i);
            exp_data = 32'(i);
            exp_mask = 4'hF;
            if (exp_ready) hs++;
            tick();
        end
        exp_valid = 1'b0;
        check("full_handshakes", 64'(hs), 64'(DEPTH));
        check("full_ready", 64'(exp_ready), 64'(0));
        pulse_start();
        repeat (5) tick();
        check("full_run_ready", 64'(exp_ready), 64'(0));
        check("full_run_done", 64'(done), 64'(0));
        expect_result(1'b0, 1'b1, 2'd2, '0, '0, 3'd0);
        wait_done("full_tmo", 40, cyc);

        // Masked lanes are don't-care
        do_reset();
        load(32'h40, 32'h0000_00AB, 4'b0001);
        pulse_start();
        expect_result(1'b1, 1'b0, 2'd0, '0, '0, 3'd1);
        store(32'h40, 32'hFFFF_FFAB, 4'b0001);
        wait_done("lane_ok", 5, cyc);

        do_reset();
        load(32'h40, 32'h0000_00AB, 4'b0001);
        pulse_start();
        expect_result(1'b0, 1'b1, 2'd1, 32'h40, 32'hFFFF_FFAB, 3'd0);
        store(32'h40, 32'hFFFF_FFAB, 4'b0011);
        wait_done("lane_sel", 5, cyc);

        // Final match on the timeout cycle wins
        do_reset();
        load(32'h10, 32'h55, 4'hF);
        pulse_start();
        repeat (TIMEOUT - 1) tick();
        check("edge_match_pre", 64'(done), 64'(0));
        expect_result(1'b1, 1'b0, 2'd0, '0, '0, 3'd1);
        store(32'h10, 32'h55, 4'hF);
        wait_done("edge_match", 5, cyc);
        check("edge_match_latency", 64'(cyc), 64'(0));

        // Mismatch on the timeout cycle beats timeout
        do_reset();
        load(32'h10, 32'h55, 4'hF);
        pulse_start();
        repeat (TIMEOUT - 1) tick();
        expect_result(1'b0, 1'b1, 2'd1, 32'h10, 32'h56, 3'd0);
        store(32'h10, 32'h56, 4'hF);
        wait_done("edge_mism", 5, cyc);

        // Handshake coincident with start joins the RUN set
        do_reset();
        load(32'h80, 32'h1, 4'hF);
        exp_valid = 1'b1; exp_addr = 32'h84; exp_data = 32'h2; exp_mask = 4'hF;
        pulse_start();
        exp_valid = 1'b0;
        store(32'h80, 32'h1, 4'hF);
        check("coinc_mid_done", 64'(done), 64'(0));
        expect_result(1'b1, 1'b0, 2'd0, '0, '0, 3'd2);
        store(32'h84, 32'h2, 4'hF);
        wait_done("coinc", 5, cyc);

        // Start with nothing loaded passes immediately
        do_reset();
        expect_result(1'b1, 1'b0, 2'd0, '0, '0, 3'd0);
        pulse_start();
        wait_done("empty", 2, cyc);

        // Reset mid-RUN abandons entries; a fresh run still passes
        do_reset();
        load(32'h20, 32'h1, 4'hF);
        load(32'h24, 32'h2, 4'hF);
        pulse_start();
        store(32'h20, 32'h1, 4'hF);
        check("midrst_mcount", 64'(match_count), 64'(1));
        check("midrst_done", 64'(done), 64'(0));
        do_reset();
        check_idle("midrst");
        load(32'h30, 32'h3, 4'hF);
        pulse_start();
        expect_result(1'b1, 1'b0, 2'd0, '0, '0, 3'd1);
        store(32'h30, 32'h3, 4'hF);
        wait_done("rerun", 5, cyc);

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
